// File: rtl/program_loader.sv
// UART-fed instruction loader: packs received bytes big-endian into 32-bit words and streams them to instruction memory.
// Optional end-of-load checksum byte is enabled by defining LOAD_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned ADDR_STEP      = 1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [31:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        loadProgram,
  output logic [31:0] addressInstrucctionProgram,
  output logic [31:0] InstructionProgram,
  output logic        write_instruction,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count,
  output logic        checksum_ok
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CHK   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]  state;
  logic [31:0] word_reg;
  logic [31:0] addr;
  logic [31:0] timer;
  logic [1:0]  byte_idx;
  logic        is_halt;
  logic        last_slot;
  logic        timed_out;

  assign is_halt   = (word_reg == HALT_WORD);
  assign last_slot = (({16'd0, word_count} + 32'd1) == MEM_DEPTH);
  assign timed_out = ((timer + 32'd1) >= TIMEOUT_CYCLES);

  assign loadProgram                = (state == RECV) || (state == WRITE) || (state == CHK);
  assign busy                       = (state == RECV) || (state == WRITE);
  assign write_instruction          = (state == WRITE);
  assign addressInstrucctionProgram = addr;
  assign InstructionProgram         = word_reg;

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_match;
  assign sum_match = (rx_data == sum);
`else
  assign checksum_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      word_reg   <= '0;
      addr       <= '0;
      timer      <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      sum         <= '0;
      checksum_ok <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= RECV;
            addr       <= '0;
            word_count <= '0;
            byte_idx   <= '0;
            timer      <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            sum         <= '0;
            checksum_ok <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (rx_done) begin
            word_reg <= {word_reg[23:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            timer    <= '0;
`ifdef LOAD_CHECKSUM_EN
            sum <= sum + rx_data;
`endif
            if (byte_idx == 2'd3) state <= WRITE;
          end else if (timed_out) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WRITE: begin
          addr       <= addr + ADDR_STEP;
          word_count <= word_count + 16'd1;
          timer      <= '0;
          if (is_halt) begin
`ifdef LOAD_CHECKSUM_EN
            // A byte arriving alongside the halt write is already the checksum.
            if (rx_done) begin
              if (sum_match) begin
                state       <= DONE;
                done        <= 1'b1;
                checksum_ok <= 1'b1;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end else begin
              state <= CHK;
            end
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else if (last_slot) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state <= RECV;
            // Accept byte 0 of the next word in the write cycle so none is lost.
            if (rx_done) begin
              word_reg <= {word_reg[23:0], rx_data};
              byte_idx <= byte_idx + 2'd1;
`ifdef LOAD_CHECKSUM_EN
              sum <= sum + rx_data;
`endif
            end
          end
        end
`ifdef LOAD_CHECKSUM_EN
        CHK: begin
          if (rx_done) begin
            if (sum_match) begin
              state       <= DONE;
              done        <= 1'b1;
              checksum_ok <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end else if (timed_out) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven loads plus timeout, overflow, reset-abort and checksum sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        loadProgram;
  logic [31:0] addressInstrucctionProgram;
  logic [31:0] InstructionProgram;
  logic        write_instruction;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;
  logic        checksum_ok;

  int unsigned errs = 0;
  int unsigned checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  program_loader #(
    .MEM_DEPTH(4),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .loadProgram(loadProgram),
    .addressInstrucctionProgram(addressInstrucctionProgram),
    .InstructionProgram(InstructionProgram),
    .write_instruction(write_instruction),
    .busy(busy),
    .done(done),
    .error(error),
    .word_count(word_count),
    .checksum_ok(checksum_ok)
  );

  always @(negedge clk) begin
    if (write_instruction) begin
      wr_addr_q.push_back(addressInstrucctionProgram);
      wr_data_q.push_back(InstructionProgram);
    end
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int unsigned gap;
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; leaves at a negedge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic run_load(input int first, input int last);
    int n;
    clear_log();
    pulse_start();
    check("load_hi_after_start", {31'd0, loadProgram}, 32'd1);
    for (int i = first; i <= last; i++) begin
      send_byte(vecs[i].b0, vecs[i].gap);
      send_byte(vecs[i].b1, vecs[i].gap);
      send_byte(vecs[i].b2, vecs[i].gap);
      send_byte(vecs[i].b3, vecs[i].gap);
    end
`ifdef LOAD_CHECKSUM_EN
    send_byte(vecs[last].csum, 0);
`endif
    wait_end();
    repeat (2) @(negedge clk);
    n = last - first + 1;
    check("write_count", wr_addr_q.size(), n);
    for (int i = first; i <= last; i++) begin
      if (i - first < wr_addr_q.size()) begin
        check("write_addr", wr_addr_q[i - first], vecs[i].exp_addr);
        check("write_word", wr_data_q[i - first], vecs[i].exp_word);
      end
    end
    check("done", {31'd0, done}, 32'd1);
    check("no_error", {31'd0, error}, 32'd0);
    check("load_lo_after", {31'd0, loadProgram}, 32'd0);
    check("busy_lo_after", {31'd0, busy}, 32'd0);
    check("word_count", {16'd0, word_count}, n);
`ifdef LOAD_CHECKSUM_EN
    check("checksum_ok", {31'd0, checksum_ok}, 32'd1);
`endif
  endtask

  initial begin
    logic [31:0] exp_ovf[4];
    logic [7:0]  bv;

    vecs[0] = '{8'h20, 8'h01, 8'h00, 8'h05, 3, 32'h20010005, 32'd0, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 32'hFFFFFFFF, 32'd1, 8'h22};
    vecs[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 32'hDEADBEEF, 32'd0, 8'h00};
    vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 32'h01020304, 32'd1, 8'h00};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 32'hFFFFFFFF, 32'd2, 8'h3E};
    exp_ovf = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    rst = 1'b0; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_load", {31'd0, loadProgram}, 32'd0);
    check("rst_addr", addressInstrucctionProgram, 32'd0);
    check("rst_word", InstructionProgram, 32'd0);
    check("rst_wr", {31'd0, write_instruction}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_count", {16'd0, word_count}, 32'd0);
    check("rst_csum", {31'd0, checksum_ok}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic load with spaced bytes, then back-to-back bytes across WRITE.
    run_load(0, 1);
    run_load(2, 4);

    // Timeout with a partial word.
    clear_log();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (50) @(negedge clk);
    check("to_not_early", {31'd0, error}, 32'd0);
    check("to_still_loading", {31'd0, loadProgram}, 32'd1);
    wait_end();
    check("to_error", {31'd0, error}, 32'd1);
    check("to_no_done", {31'd0, done}, 32'd0);
    check("to_no_write", wr_addr_q.size(), 32'd0);
    check("to_count", {16'd0, word_count}, 32'd0);
    check("to_load_lo", {31'd0, loadProgram}, 32'd0);

    // Overflow: 5 non-halt words into a 4-deep memory.
    clear_log();
    pulse_start();
    for (int w = 0; w < 5; w++) begin
      bv = 8'(8'h11 * (w + 1));
      for (int k = 0; k < 4; k++) send_byte(bv, 1);
    end
    wait_end();
    repeat (2) @(negedge clk);
    check("ovf_writes", wr_addr_q.size(), 32'd4);
    for (int w = 0; w < 4; w++) begin
      if (w < wr_addr_q.size()) begin
        check("ovf_addr", wr_addr_q[w], w);
        check("ovf_word", wr_data_q[w], exp_ovf[w]);
      end
    end
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_no_done", {31'd0, done}, 32'd0);
    check("ovf_count", {16'd0, word_count}, 32'd4);
    check("ovf_load_lo", {31'd0, loadProgram}, 32'd0);

    // Reset mid-load; a start pulse while busy must be ignored.
    clear_log();
    pulse_start();
    send_byte(8'hCA, 1); send_byte(8'hFE, 1); send_byte(8'hF0, 1); send_byte(8'h0D, 1);
    pulse_start();
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h56, 1); send_byte(8'h78, 1);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_load", {31'd0, loadProgram}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {16'd0, word_count}, 32'd0);
    check("mid_rst_addr", addressInstrucctionProgram, 32'd0);
    check("mid_rst_word", InstructionProgram, 32'd0);
    check("mid_rst_wr", {31'd0, write_instruction}, 32'd0);
    send_byte(8'hEE, 0); send_byte(8'hEE, 0);
    rst = 1'b1;
    send_byte(8'hEE, 0); send_byte(8'hEE, 0);
    repeat (5) @(negedge clk);
    check("mid_rst_writes", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("mid_rst_a0", wr_addr_q[0], 32'd0);
      check("mid_rst_w0", wr_data_q[0], 32'hCAFEF00D);
      check("mid_rst_a1", wr_addr_q[1], 32'd1);
      check("mid_rst_w1", wr_data_q[1], 32'h12345678);
    end
    run_load(0, 1);

`ifdef LOAD_CHECKSUM_EN
    // Checksum good then bad.
    clear_log();
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 0);
    send_byte(8'hFC, 0);
    wait_end();
    check("cs_done", {31'd0, done}, 32'd1);
    check("cs_ok", {31'd0, checksum_ok}, 32'd1);
    check("cs_no_error", {31'd0, error}, 32'd0);
    check("cs_count", {16'd0, word_count}, 32'd2);
    pulse_start();
    check("cs_ok_cleared", {31'd0, checksum_ok}, 32'd0);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 1);
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1);
    send_byte(8'h00, 0);
    wait_end();
    repeat (2) @(negedge clk);
    check("cs_bad_error", {31'd0, error}, 32'd1);
    check("cs_bad_done", {31'd0, done}, 32'd0);
    check("cs_bad_ok", {31'd0, checksum_ok}, 32'd0);
    check("cs_bad_writes", wr_addr_q.size(), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
